// File: rtl/mc_pkg.sv
// mc_pkg: encodings shared by the multicycle datapath and its control FSM.
package mc_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_NOR = 2'b10,
        ALU_AND = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_B      = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } srcb_e;

    typedef enum logic [1:0] {
        PCS_ALU  = 2'b00,
        PCS_C    = 2'b01,
        PCS_JUMP = 2'b10,
        PCS_HOLD = 2'b11
    } pcsrc_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_NOR = 6'h27;

    function automatic logic [DW-1:0] sext16(input logic [15:0] v);
        return {{(DW-16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 32x32 register file, two async read ports, one sync write port, $0 hardwired.
// Optional combinational debug read port under MC_DP_DEBUG_PORT_EN.
module mc_regfile
    import mc_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] i_ra1,
    input  logic [RW-1:0] i_ra2,
    input  logic          i_we,
    input  logic [RW-1:0] i_wa,
    input  logic [DW-1:0] i_wd,
`ifdef MC_DP_DEBUG_PORT_EN
    input  logic [RW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_dbg_data,
`endif
    output logic [DW-1:0] o_rd1,
    output logic [DW-1:0] o_rd2
);

    // Entry 0 has no storage; reads of $0 are forced to zero.
    logic [DW-1:0] r_regs [31:1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) r_regs[i] <= '0;
        end else if (i_we && i_wa != '0) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];

`ifdef MC_DP_DEBUG_PORT_EN
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
`endif

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle MIPS-subset datapath (PC/IR/MDR/A/B/C, regfile, inline ALU).
// Define MC_DP_DEBUG_PORT_EN to expose a register-file debug read port.
module mc_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_pc,
    input  logic        iord,
    input  logic        write_mem,
    input  logic        write_dr,
    input  logic        write_ir,
    input  logic        memtoreg,
    input  logic        regdst,
    input  logic        write_c,
    input  logic        alu_srcA,
    input  logic        write_a,
    input  logic        write_b,
    input  logic        write_reg,
    input  logic [1:0]  pcsource,
    input  logic [1:0]  alu_ctrl,
    input  logic [1:0]  alu_srcB,
`ifdef MC_DP_DEBUG_PORT_EN
    input  logic [4:0]  dbg_reg_addr,
    output logic [31:0] dbg_reg_data,
`endif
    output logic [31:0] ir_data,
    output logic        zero,
    output logic [31:0] pc,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_c;
    logic [31:0] w_rd1, w_rd2, w_imm, w_src_a, w_src_b, w_alu, w_next_pc;

    mc_regfile u_rf (
        .clk        (clk),
        .rst        (rst),
        .i_ra1      (r_ir[25:21]),
        .i_ra2      (r_ir[20:16]),
        .i_we       (write_reg),
        .i_wa       (regdst ? r_ir[15:11] : r_ir[20:16]),
        .i_wd       (memtoreg ? r_mdr : r_c),
`ifdef MC_DP_DEBUG_PORT_EN
        .i_dbg_addr (dbg_reg_addr),
        .o_dbg_data (dbg_reg_data),
`endif
        .o_rd1      (w_rd1),
        .o_rd2      (w_rd2)
    );

    assign w_imm   = sext16(r_ir[15:0]);
    assign w_src_a = alu_srcA ? r_a : r_pc;

    always_comb begin
        w_src_b = r_b;
        case (srcb_e'(alu_srcB))
            SRCB_B:      w_src_b = r_b;
            SRCB_FOUR:   w_src_b = 32'd4;
            SRCB_IMM:    w_src_b = w_imm;
            SRCB_IMM_SH: w_src_b = {w_imm[29:0], 2'b00};
        endcase
    end

    always_comb begin
        w_alu = '0;
        case (alu_op_e'(alu_ctrl))
            ALU_ADD: w_alu = w_src_a + w_src_b;
            ALU_SUB: w_alu = w_src_a - w_src_b;
            ALU_AND: w_alu = w_src_a & w_src_b;
            ALU_NOR: w_alu = ~(w_src_a | w_src_b);
        endcase
    end

    always_comb begin
        w_next_pc = r_pc;
        case (pcsrc_e'(pcsource))
            PCS_ALU:  w_next_pc = w_alu;
            PCS_C:    w_next_pc = r_c;
            PCS_JUMP: w_next_pc = {r_pc[31:28], r_ir[25:0], 2'b00};
            PCS_HOLD: w_next_pc = r_pc;
        endcase
    end

    // Every register samples pre-edge values, so same-edge strobes see old state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_mdr <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
        end else begin
            if (write_pc) r_pc  <= w_next_pc;
            if (write_ir) r_ir  <= mem_rdata;
            if (write_dr) r_mdr <= mem_rdata;
            if (write_a)  r_a   <= w_rd1;
            if (write_b)  r_b   <= w_rd2;
            if (write_c)  r_c   <= w_alu;
        end
    end

    assign ir_data   = r_ir;
    assign zero      = (w_alu == '0);
    assign pc        = r_pc;
    assign mem_addr  = iord ? r_c : r_pc;
    assign mem_wdata = r_b;
    assign mem_we    = write_mem;

endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed self-checking bench for mc_datapath.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_pc, iord, write_mem, write_dr, write_ir, memtoreg, regdst;
    logic        write_c, alu_srcA, write_a, write_b, write_reg;
    logic [1:0]  pcsource, alu_ctrl, alu_srcB;
    logic [31:0] ir_data, pc, mem_addr, mem_wdata, mem_rdata;
    logic        zero, mem_we;
`ifdef MC_DP_DEBUG_PORT_EN
    logic [4:0]  dbg_reg_addr = 5'd0;
    logic [31:0] dbg_reg_data;
`endif

    logic [31:0] mem [0:255];
    logic        use_mem;
    logic [31:0] rd_val;
    logic [31:0] v;
    int          checks = 0;
    int          failures = 0;

    assign mem_rdata = use_mem ? mem[mem_addr[9:2]] : rd_val;

    always #5 clk = ~clk;

    mc_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .write_pc     (write_pc),
        .iord         (iord),
        .write_mem    (write_mem),
        .write_dr     (write_dr),
        .write_ir     (write_ir),
        .memtoreg     (memtoreg),
        .regdst       (regdst),
        .write_c      (write_c),
        .alu_srcA     (alu_srcA),
        .write_a      (write_a),
        .write_b      (write_b),
        .write_reg    (write_reg),
        .pcsource     (pcsource),
        .alu_ctrl     (alu_ctrl),
        .alu_srcB     (alu_srcB),
`ifdef MC_DP_DEBUG_PORT_EN
        .dbg_reg_addr (dbg_reg_addr),
        .dbg_reg_data (dbg_reg_data),
`endif
        .ir_data      (ir_data),
        .zero         (zero),
        .pc           (pc),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        {write_pc, iord, write_mem, write_dr, write_ir, memtoreg, regdst} = '0;
        {write_c, alu_srcA, write_a, write_b, write_reg} = '0;
        pcsource = 2'b11;
        alu_ctrl = 2'b00;
        alu_srcB = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [31:0] val);
        use_mem  = 1'b0;
        rd_val   = val;
        write_ir = 1'b1;
        tick();
        write_ir = 1'b0;
    endtask

    task automatic set_reg(input logic [4:0] r, input logic [31:0] val);
        load_ir({6'h23, 5'd0, r, 16'd0});
        rd_val   = val;
        write_dr = 1'b1;
        tick();
        idle();
        write_reg = 1'b1;
        memtoreg  = 1'b1;
        tick();
        idle();
    endtask

    // C <= A + sext(IR[15:0]); callers keep the immediate at zero to copy A.
    task automatic c_from_a();
        alu_srcA = 1'b1;
        alu_srcB = 2'b10;
        alu_ctrl = 2'b00;
        write_c  = 1'b1;
        tick();
        idle();
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] val);
        load_ir({6'h23, r, 5'd0, 16'd0});
        write_a = 1'b1;
        tick();
        idle();
        c_from_a();
        iord = 1'b1;
        #1 val = mem_addr;
        iord = 1'b0;
    endtask

    task automatic alu_op(input string tag, input logic [1:0] op, input logic [31:0] exp);
        alu_srcA = 1'b1;
        alu_srcB = 2'b00;
        alu_ctrl = op;
        write_c  = 1'b1;
        tick();
        idle();
        iord = 1'b1;
        #1 chk(tag, mem_addr, exp);
        iord = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0]  = 32'h8D28_FFFC;
        mem[7]  = 32'h0000_CAFE;
        use_mem = 1'b0;
        rd_val  = '0;
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // reset mid-run
        set_reg(5'd5, 32'h55);
        write_pc = 1'b1; pcsource = 2'b00; alu_srcB = 2'b01;
        tick();
        tick();
        idle();
        rst = 1'b0;
        write_mem = 1'b1;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir_data, 32'h0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd1);
        write_mem = 1'b0;
        tick();
        rst = 1'b1;

        // first fetch after release
        use_mem  = 1'b1;
        write_pc = 1'b1; write_ir = 1'b1; pcsource = 2'b00; alu_srcB = 2'b01;
        tick();
        idle();
        chk("fetch_pc", pc, 32'h4);
        chk("fetch_ir", ir_data, 32'h8D28_FFFC);
        read_reg(5'd5, v);
        chk("rst_rf5", v, 32'h0);

        // ALU ops with A=5, B=3
        set_reg(5'd1, 32'd5);
        set_reg(5'd2, 32'd3);
        load_ir({6'h00, 5'd1, 5'd2, 16'd0});
        write_a = 1'b1; write_b = 1'b1;
        tick();
        idle();
        alu_op("alu_add", 2'b00, 32'd8);
        alu_srcA = 1'b1; alu_ctrl = 2'b01;
        #1 chk("zero_sub_ne", {31'd0, zero}, 32'd0);
        idle();
        alu_op("alu_sub", 2'b01, 32'd2);
        alu_op("alu_and", 2'b11, 32'd1);
        alu_op("alu_nor", 2'b10, 32'hFFFF_FFF8);
        set_reg(5'd3, 32'd7);
        load_ir({6'h00, 5'd3, 5'd3, 16'd0});
        write_a = 1'b1; write_b = 1'b1;
        tick();
        idle();
        alu_srcA = 1'b1; alu_ctrl = 2'b01;
        #1 chk("zero_sub_eq", {31'd0, zero}, 32'd1);
        idle();

        // load path: lw $8, -4($9)
        set_reg(5'd9, 32'h20);
        load_ir(32'h8D28_FFFC);
        write_a = 1'b1;
        tick();
        idle();
        alu_srcA = 1'b1; alu_srcB = 2'b10; write_c = 1'b1;
        tick();
        idle();
        iord = 1'b1; use_mem = 1'b1;
        #1 chk("lw_addr", mem_addr, 32'h1C);
        write_dr = 1'b1;
        tick();
        idle();
        write_reg = 1'b1; memtoreg = 1'b1;
        tick();
        idle();
        read_reg(5'd8, v);
        chk("lw_rf8", v, 32'h0000_CAFE);

        // store path
        set_reg(5'd10, 32'h1234);
        set_reg(5'd11, 32'h40);
        load_ir({6'h2B, 5'd11, 5'd10, 16'd0});
        write_a = 1'b1; write_b = 1'b1;
        tick();
        idle();
        c_from_a();
        iord = 1'b1; write_mem = 1'b1;
        #1;
        chk("sw_addr", mem_addr, 32'h40);
        chk("sw_wdata", mem_wdata, 32'h1234);
        chk("sw_we", {31'd0, mem_we}, 32'd1);
        tick();
        idle();
        #1 chk("sw_we_off", {31'd0, mem_we}, 32'd0);

        // jump and PC-from-C
        set_reg(5'd12, 32'h3000_0010);
        read_reg(5'd12, v);
        write_pc = 1'b1; pcsource = 2'b01;
        tick();
        idle();
        chk("pc_from_c", pc, 32'h3000_0010);
        load_ir(32'h0800_0100);
        write_pc = 1'b1; pcsource = 2'b10;
        tick();
        idle();
        chk("jump_pc", pc, 32'h3000_0400);
        alu_srcB = 2'b01; write_c = 1'b1;
        tick();
        idle();
        write_pc = 1'b1; pcsource = 2'b01; write_c = 1'b1; alu_srcB = 2'b10;
        tick();
        idle();
        chk("pc_old_c", pc, 32'h3000_0404);
        iord = 1'b1;
        #1 chk("c_new", mem_addr, 32'h3000_0500);
        iord = 1'b0;

        // write to $0 discarded
        set_reg(5'd13, 32'hFFFF);
        read_reg(5'd13, v);
        load_ir(32'h0);
        write_reg = 1'b1; regdst = 1'b1;
        tick();
        idle();
        read_reg(5'd0, v);
        chk("r0_zero", v, 32'h0);

        // same-edge regfile write and A capture: no bypass
        set_reg(5'd4, 32'h11);
        load_ir({6'h23, 5'd4, 5'd4, 16'd0});
        rd_val = 32'h22; write_dr = 1'b1;
        tick();
        idle();
        write_reg = 1'b1; memtoreg = 1'b1; write_a = 1'b1;
        tick();
        idle();
        c_from_a();
        iord = 1'b1;
        #1 chk("a_old_rf4", mem_addr, 32'h11);
        iord = 1'b0;
        read_reg(5'd4, v);
        chk("rf4_new", v, 32'h22);

`ifdef MC_DP_DEBUG_PORT_EN
        dbg_reg_addr = 5'd8;
        #1 chk("dbg_rf8", dbg_reg_data, 32'h0000_CAFE);
        dbg_reg_addr = 5'd0;
        #1 chk("dbg_rf0", dbg_reg_data, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multicycle MIPS-subset datapath that consumes the per-cycle control strobes of the multicycle control FSM and returns `ir_data` and `zero` to it. Holds PC, IR, MDR, A, B and ALU-out (C) registers, the 32×32 register file and the ALU. Drives a unified instruction/data memory port with combinational read.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `write_pc, iord, write_mem, write_dr, write_ir, memtoreg, regdst, write_c, alu_srcA, write_a, write_b, write_reg`  in  1 each  control strobes.
- `pcsource`  in  2  next-PC select.
- `alu_ctrl`  in  2  00 add, 01 sub, 11 and, 10 nor.
- `alu_srcB`  in  2  ALU B-operand select.
- `ir_data`  out  32  IR contents.
- `zero`  out  1  ALU result == 0, combinational.
- `pc`  out  32  current PC.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  32  memory read data, valid in the same cycle as `mem_addr`.

## Operation
- ALU A operand: `alu_srcA` 0 → PC, 1 → A.
- ALU B operand:
  - 00 → B
  - 01 → 32'd4
  - 10 → sign-extended IR[15:0]
  - 11 → sign-extended IR[15:0] << 2
- ALU arithmetic: 32-bit, wrap-around, no overflow flag. `zero` = (alu_result == 0).
- Next PC:
  - `pcsource` 00 → alu_result
  - 01 → C
  - 10 → {PC[31:28], IR[25:0], 2'b00}
  - 11 → PC (hold)
- Loads, each on the rising edge:
  - PC loads next PC when `write_pc`.
  - IR ← mem_rdata when `write_ir`.
  - MDR ← mem_rdata when `write_dr`.
  - A ← RF[IR[25:21]] when `write_a`.
  - B ← RF[IR[20:16]] when `write_b`.
  - C ← alu_result when `write_c`.
- Register write when `write_reg`:
  - destination = `regdst` ? IR[15:11] : IR[20:16]
  - data = `memtoreg` ? MDR : C
  - Writes to $0 are discarded; $0 always reads 0.
- Memory port: `mem_addr` = `iord` ? C : PC. `mem_wdata` = B. `mem_we` = `write_mem`.

## Timing
- Reset (rst low, asynchronous) sets:
  - PC = RESET_PC
  - IR, MDR, A, B, C = 0
  - all 32 RF entries = 0
- Resulting output values during reset: `ir_data` = 0; `zero` = 1 if the controls select a zero-result operation; `mem_we` follows `write_mem`.
- Release of reset is synchronous to the next rising edge.
- All register updates take one edge. Values written are visible on outputs and register reads in the following cycle.
- Simultaneous strobes all take effect on the same edge. Each register samples its pre-edge inputs:
  - `write_pc` with `pcsource`=01 and `write_c` → PC takes the old C.
  - `write_reg` with `write_a`/`write_b` on the same index → A/B capture the old RF value. No bypass.
  - `write_ir` with `write_a` → A indexes with the old IR.
- Reset asserted mid-instruction aborts immediately and discards all partial state. No memory write occurs while rst is low unless `write_mem` is driven high.
- Memory read is combinational. `mem_rdata` must settle within the same cycle: a load completes through MDR in one edge.

## Configuration
- `MC_DP_DEBUG_PORT_EN` defined:
  - Adds input `dbg_reg_addr` [4:0] and output `dbg_reg_data` [31:0].
  - `dbg_reg_data` is a combinational read of RF[dbg_reg_addr]; $0 reads 0.
- Not defined: both ports are absent, with no other behavioural change.

## Structure
- Shared package `mc_pkg` holds:
  - ALU op encodings (ADD/SUB/AND/NOR)
  - srcB encodings
  - pcsource encodings
  - opcode/funct constants
- The package is shared with the control FSM.
- One sub-module, `mc_regfile`: 2 combinational read ports, 1 synchronous write port, asynchronous active-low clear, $0 hardwired, plus the optional debug read port.
- The ALU stays inline.

## Test plan
- Reset: hold rst low with PC mid-run → PC = RESET_PC, `ir_data` = 0, RF[5] = 0. Release → first edge with `write_pc`, `write_ir`, srcA=0, srcB=01, add → PC = 4, IR = mem[0].
- ALU ops with A=5, B=3, srcA=1, srcB=00:
  - add → C = 8
  - sub → C = 2, `zero` = 0
  - and → C = 1
  - nor → C = 32'hFFFF_FFF8
  - A=B=7 with sub → `zero` = 1
- Load path: IR = lw $8, -4($9), RF[9] = 0x20, mem[0x1C] = 0xCAFE → C = 0x1C, `mem_addr` = 0x1C with `iord`, MDR = 0xCAFE, RF[8] = 0xCAFE after `write_reg`/`memtoreg`/`regdst`=0.
- Store path: B = 0x1234, C = 0x40, `iord`=1, `write_mem`=1 → `mem_addr` = 0x40, `mem_wdata` = 0x1234, `mem_we` = 1 for exactly that cycle.
- Jump and branch:
  - PC = 0x3000_0010, IR = j 0x0000_100 → `pcsource`=10 gives PC = 0x3000_0400.
  - `pcsource`=01 with `write_c` in the same cycle → PC takes the old C.
- Corner cases:
  - `write_reg` to $0 with C = 0xFFFF → RF[0] still reads 0.
  - Same-edge `write_reg` to $4 and `write_a` indexing $4 → A gets the pre-write value.
